// File: rtl/ad9228_pkg.sv
// ---------------------------------------------------------------------------
// ad9228_pkg
// Shared types and constants for the AD9228 channel-FIFO drain scheduler.
//   state_e  : drain FSM state encoding
//   ch_w()   : channel-select width for a given channel count (min 1 bit)
//   CH_W     : channel-select width for the default 4-channel configuration
// ---------------------------------------------------------------------------
package ad9228_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StRead,
        StCapture,
        StOut
    } state_e;

    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned NUM_CHANNELS_DEF = 4;
    localparam int unsigned CH_W             = ch_w(NUM_CHANNELS_DEF);

endpackage

// File: rtl/ad9228_rr_ptr.sv
// ---------------------------------------------------------------------------
// ad9228_rr_ptr
// Wrap-around channel pointer: holds, or advances by one per cycle when
// i_advance is high, wrapping NUM_CHANNELS-1 -> 0.
//   i_clk     : clock
//   i_rst     : synchronous active-high reset (pointer -> 0)
//   i_advance : step the pointer on this edge
//   o_ptr     : current channel (flop output)
// ---------------------------------------------------------------------------
module ad9228_rr_ptr
    import ad9228_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned ADDR_W       = ch_w(NUM_CHANNELS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_ptr
);

    logic [ADDR_W-1:0] r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (r_ptr == ADDR_W'(NUM_CHANNELS - 1)) ? '0 : r_ptr + ADDR_W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/ad9228_fifo_drain_sched.sv
// ---------------------------------------------------------------------------
// ad9228_fifo_drain_sched
// Round-robin drain of per-channel ADC FIFOs into a valid/ready stream, with
// up to max(burst_max,1) words per channel grant. All outputs are registered.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_enable              : run/stop the drain sequence
//   i_chan_mask           : 1 = channel eligible for service
//   i_burst_max           : max words per grant (0 treated as 1)
//   o_fifo_addr           : channel select to the external FIFO mux
//   o_fifo_rd_en          : one-hot read strobe
//   i_fifo_not_empty/full : muxed status of the addressed FIFO
//   i_fifo_dout           : muxed data, valid one cycle after rd_en
//   o_m_data/o_m_chan     : output sample and its source channel
//   o_m_valid, i_m_ready  : output handshake
//   o_busy                : FSM not idle
//   o_overflow            : sticky per-channel full flags
//   i_overflow_clr        : clear all overflow flags (a same-cycle set wins)
// ---------------------------------------------------------------------------
module ad9228_fifo_drain_sched
    import ad9228_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned DATA_WIDTH   = 12,
    parameter int unsigned BURST_W      = 8,
    localparam int unsigned ADDR_W      = ch_w(NUM_CHANNELS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic [NUM_CHANNELS-1:0] i_chan_mask,
    input  logic [BURST_W-1:0]      i_burst_max,
    output logic [ADDR_W-1:0]       o_fifo_addr,
    output logic [NUM_CHANNELS-1:0] o_fifo_rd_en,
    input  logic                    i_fifo_not_empty,
    input  logic                    i_fifo_full,
    input  logic [DATA_WIDTH-1:0]   i_fifo_dout,
    output logic [DATA_WIDTH-1:0]   o_m_data,
    output logic [ADDR_W-1:0]       o_m_chan,
    output logic                    o_m_valid,
    input  logic                    i_m_ready,
    output logic                    o_busy,
    output logic [NUM_CHANNELS-1:0] o_overflow,
    input  logic                    i_overflow_clr
);

    state_e                  r_state, w_state_d;
    logic [ADDR_W-1:0]       w_ptr;
    logic                    w_ptr_adv;
    logic [BURST_W-1:0]      r_burst_cnt, w_burst_cnt_d;
    logic [BURST_W-1:0]      w_burst_lim;
    logic                    w_sel_ok;
    logic [NUM_CHANNELS-1:0] w_ptr_onehot;
    logic [NUM_CHANNELS-1:0] r_rd_en, w_rd_en_d;
    logic [DATA_WIDTH-1:0]   r_m_data, w_m_data_d;
    logic [ADDR_W-1:0]       r_m_chan, w_m_chan_d;
    logic                    r_m_valid, w_m_valid_d;
    logic                    r_busy, w_busy_d;
    logic [NUM_CHANNELS-1:0] r_overflow, w_overflow_d;

    // The pointer flop drives the FIFO mux select directly.
    ad9228_rr_ptr #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .ADDR_W       (ADDR_W)
    ) u_rr_ptr (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_advance (w_ptr_adv),
        .o_ptr     (w_ptr)
    );

    assign w_burst_lim  = (i_burst_max == '0) ? BURST_W'(1) : i_burst_max;
    assign w_sel_ok     = i_chan_mask[w_ptr] && i_fifo_not_empty;
    assign w_ptr_onehot = NUM_CHANNELS'(1) << w_ptr;

    always_comb begin
        w_state_d     = r_state;
        w_ptr_adv     = 1'b0;
        w_burst_cnt_d = r_burst_cnt;
        w_rd_en_d     = '0;
        w_m_data_d    = r_m_data;
        w_m_chan_d    = r_m_chan;
        w_m_valid_d   = r_m_valid;

        unique case (r_state)
            StIdle: begin
                if (i_enable) w_state_d = StScan;
            end
            StScan: begin
                if (!i_enable) begin
                    w_state_d = StIdle;
                end else if (w_sel_ok) begin
                    // rd_en is registered, so it is raised on entry to READ.
                    w_state_d = StRead;
                    w_rd_en_d = w_ptr_onehot;
                end else begin
                    w_ptr_adv = 1'b1;
                end
            end
            StRead: begin
                w_state_d = StCapture;
            end
            StCapture: begin
                w_m_data_d    = i_fifo_dout;
                w_m_chan_d    = w_ptr;
                w_m_valid_d   = 1'b1;
                w_burst_cnt_d = r_burst_cnt + BURST_W'(1);
                w_state_d     = StOut;
            end
            StOut: begin
                if (i_m_ready) begin
                    w_m_valid_d = 1'b0;
                    if (i_enable && w_sel_ok && (r_burst_cnt < w_burst_lim)) begin
                        w_state_d = StRead;
                        w_rd_en_d = w_ptr_onehot;
                    end else begin
                        w_ptr_adv     = 1'b1;
                        w_burst_cnt_d = '0;
                        w_state_d     = i_enable ? StScan : StIdle;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        w_busy_d = (w_state_d != StIdle);
    end

    // Set beats clear: the full flag is applied after the clear.
    always_comb begin
        w_overflow_d = i_overflow_clr ? '0 : r_overflow;
        if (i_fifo_full) w_overflow_d[w_ptr] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_burst_cnt <= '0;
            r_rd_en     <= '0;
            r_m_data    <= '0;
            r_m_chan    <= '0;
            r_m_valid   <= 1'b0;
            r_busy      <= 1'b0;
            r_overflow  <= '0;
        end else begin
            r_state     <= w_state_d;
            r_burst_cnt <= w_burst_cnt_d;
            r_rd_en     <= w_rd_en_d;
            r_m_data    <= w_m_data_d;
            r_m_chan    <= w_m_chan_d;
            r_m_valid   <= w_m_valid_d;
            r_busy      <= w_busy_d;
            r_overflow  <= w_overflow_d;
        end
    end

    assign o_fifo_addr  = w_ptr;
    assign o_fifo_rd_en = r_rd_en;
    assign o_m_data     = r_m_data;
    assign o_m_chan     = r_m_chan;
    assign o_m_valid    = r_m_valid;
    assign o_busy       = r_busy;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_ad9228_fifo_drain_sched.sv
// ---------------------------------------------------------------------------
// tb_ad9228_fifo_drain_sched
// Directed bench for ad9228_fifo_drain_sched with a four-channel FIFO model.
// Word k (1-based) of channel c reads back as {c[3:0], k[7:0]}.
// ---------------------------------------------------------------------------
module tb_ad9228_fifo_drain_sched;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [3:0]  chan_mask;
    logic [7:0]  burst_max;
    logic [1:0]  fifo_addr;
    logic [3:0]  fifo_rd_en;
    logic        fifo_not_empty;
    logic        fifo_full;
    logic [11:0] fifo_dout;
    logic [11:0] m_data;
    logic [1:0]  m_chan;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic [3:0]  overflow;
    logic        overflow_clr;

    int unsigned n_cmp;
    int unsigned n_err;

    ad9228_fifo_drain_sched #(
        .NUM_CHANNELS (4),
        .DATA_WIDTH   (12),
        .BURST_W      (8)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_enable         (enable),
        .i_chan_mask      (chan_mask),
        .i_burst_max      (burst_max),
        .o_fifo_addr      (fifo_addr),
        .o_fifo_rd_en     (fifo_rd_en),
        .i_fifo_not_empty (fifo_not_empty),
        .i_fifo_full      (fifo_full),
        .i_fifo_dout      (fifo_dout),
        .o_m_data         (m_data),
        .o_m_chan         (m_chan),
        .o_m_valid        (m_valid),
        .i_m_ready        (m_ready),
        .o_busy           (busy),
        .o_overflow       (overflow),
        .i_overflow_clr   (overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: depth counters only, data derived from channel and index.
    logic        tb_clr;
    logic        tb_load;
    logic [1:0]  tb_ch;
    int unsigned tb_n;
    int unsigned f_cnt [4];
    int unsigned f_head [4];

    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 4; i++) begin
                f_cnt[i]  <= 0;
                f_head[i] <= 0;
            end
            fifo_dout <= '0;
        end else begin
            if (tb_load) begin
                f_cnt[tb_ch]  <= tb_n;
                f_head[tb_ch] <= 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (fifo_rd_en[i] && f_cnt[i] != 0) begin
                    f_cnt[i]  <= f_cnt[i] - 1;
                    f_head[i] <= f_head[i] + 1;
                    fifo_dout <= {4'(i), 8'(f_head[i] + 1)};
                end
            end
        end
    end

    assign fifo_not_empty = (f_cnt[fifo_addr] != 0);

    // Monitor: handshakes, read pulses, reads of any channel other than 2.
    int unsigned hs_cnt;
    int unsigned rd_cnt;
    int unsigned off2_cnt;
    logic [1:0]  hs_chan [16];
    logic [11:0] hs_data [16];

    always @(negedge clk) begin
        if (tb_clr) begin
            hs_cnt   <= 0;
            rd_cnt   <= 0;
            off2_cnt <= 0;
        end else begin
            if (m_valid && m_ready) begin
                if (hs_cnt < 16) begin
                    hs_chan[hs_cnt[3:0]] <= m_chan;
                    hs_data[hs_cnt[3:0]] <= m_data;
                end
                hs_cnt <= hs_cnt + 1;
            end
            if (fifo_rd_en != 4'b0000) rd_cnt <= rd_cnt + 1;
            if (fifo_rd_en != 4'b0000 && fifo_rd_en != 4'b0100) off2_cnt <= off2_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        enable       = 1'b0;
        m_ready      = 1'b0;
        fifo_full    = 1'b0;
        overflow_clr = 1'b0;
        tb_load      = 1'b0;
        tb_clr       = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        tb_clr = 1'b0;
    endtask

    task automatic load(input logic [1:0] ch, input int unsigned n);
        tb_ch   = ch;
        tb_n    = n;
        tb_load = 1'b1;
        tick();
        tb_load = 1'b0;
    endtask

    localparam logic [1:0]  S1_CH   [6] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd2};
    localparam logic [11:0] S1_DATA [6] = '{12'h001, 12'h002, 12'h201, 12'h202,
                                            12'h003, 12'h203};

    initial begin
        logic        seen;
        int unsigned stable;

        n_cmp     = 0;
        n_err     = 0;
        chan_mask = 4'b0000;
        burst_max = 8'd1;
        tb_ch     = 2'd0;
        tb_n      = 0;
        do_reset();

        // Reset state
        check_eq("rst_m_valid", 32'(m_valid), 32'd0);
        check_eq("rst_m_data", 32'(m_data), 32'd0);
        check_eq("rst_m_chan", 32'(m_chan), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check_eq("rst_addr", 32'(fifo_addr), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);

        // S1: two channels, burst of 2, continuous ready
        load(2'd0, 3);
        load(2'd2, 3);
        chan_mask = 4'b1111;
        burst_max = 8'd2;
        m_ready   = 1'b1;
        enable    = 1'b1;
        tick();
        check_eq("s1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 300 && hs_cnt < 6; i++) tick();
        check_eq("s1_count", hs_cnt, 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("s1_chan%0d", i), 32'(hs_chan[i]), 32'(S1_CH[i]));
            check_eq($sformatf("s1_data%0d", i), 32'(hs_data[i]), 32'(S1_DATA[i]));
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_eq("s1_idle", 32'(busy), 32'd0);
        check_eq("s1_reads", rd_cnt, 32'd6);

        // S2: single word held under backpressure
        do_reset();
        load(2'd1, 1);
        chan_mask = 4'b1111;
        burst_max = 8'd2;
        enable    = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (m_valid) seen = 1'b1;
        end
        check_eq("s2_valid", 32'(seen), 32'd1);
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_valid && m_data == 12'h101 && m_chan == 2'd1) stable++;
        end
        check_eq("s2_stable", stable, 32'd10);
        m_ready = 1'b1;
        tick();
        check_eq("s2_valid_drop", 32'(m_valid), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check_eq("s2_hs", hs_cnt, 32'd1);
        check_eq("s2_data", 32'(hs_data[0]), 32'h101);
        check_eq("s2_reads", rd_cnt, 32'd1);

        // S3: only ch2 eligible, burst_max 0 behaves as 1
        do_reset();
        for (int c = 0; c < 4; c++) load(2'(c), 2);
        chan_mask = 4'b0100;
        burst_max = 8'd0;
        m_ready   = 1'b1;
        enable    = 1'b1;
        for (int i = 0; i < 100 && hs_cnt < 2; i++) tick();
        for (int i = 0; i < 20; i++) tick();
        check_eq("s3_hs", hs_cnt, 32'd2);
        check_eq("s3_reads", rd_cnt, 32'd2);
        check_eq("s3_off_ch2", off2_cnt, 32'd0);
        check_eq("s3_chan0", 32'(hs_chan[0]), 32'd2);
        check_eq("s3_data0", 32'(hs_data[0]), 32'h201);
        check_eq("s3_data1", 32'(hs_data[1]), 32'h202);
        enable = 1'b0;

        // S4: enable dropped the cycle after READ
        do_reset();
        load(2'd3, 2);
        chan_mask = 4'b1111;
        burst_max = 8'd4;
        m_ready   = 1'b1;
        enable    = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (fifo_rd_en != 4'b0000) seen = 1'b1;
        end
        check_eq("s4_read_seen", 32'(seen), 32'd1);
        tick();
        enable = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_eq("s4_hs", hs_cnt, 32'd1);
        check_eq("s4_data", 32'(hs_data[0]), 32'h301);
        check_eq("s4_busy", 32'(busy), 32'd0);
        check_eq("s4_reads", rd_cnt, 32'd1);

        // S5: overflow set wins over a same-cycle clear
        do_reset();
        chan_mask = 4'b0000;
        enable    = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (fifo_addr == 2'd3) seen = 1'b1;
        end
        check_eq("s5_addr3", 32'(seen), 32'd1);
        fifo_full    = 1'b1;
        overflow_clr = 1'b1;
        enable       = 1'b0;
        tick();
        fifo_full    = 1'b0;
        overflow_clr = 1'b0;
        check_eq("s5_ovf_set", 32'(overflow), 32'h8);
        tick();
        tick();
        check_eq("s5_ovf_sticky", 32'(overflow), 32'h8);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check_eq("s5_ovf_clr", 32'(overflow), 32'h0);
        check_eq("s5_reads", rd_cnt, 32'd0);

        // S6: reset while a word waits in OUT
        do_reset();
        load(2'd0, 1);
        chan_mask = 4'b1111;
        burst_max = 8'd1;
        enable    = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (m_valid) seen = 1'b1;
        end
        check_eq("s6_valid", 32'(seen), 32'd1);
        rst    = 1'b1;
        enable = 1'b0;
        tick();
        rst = 1'b0;
        check_eq("s6_m_valid", 32'(m_valid), 32'd0);
        check_eq("s6_busy", 32'(busy), 32'd0);
        check_eq("s6_rd_en", 32'(fifo_rd_en), 32'd0);
        check_eq("s6_m_data", 32'(m_data), 32'd0);
        check_eq("s6_addr", 32'(fifo_addr), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check_eq("s6_reads", rd_cnt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
